// File: rtl/keymux_pkg.sv
// Shared constants and width helper for the keyed round-robin stream mux family.
package keymux_pkg;

   localparam int DEF_NR_CH    = 4;
   localparam int DEF_DATA_LEN = 8;

   // Smallest r with 2**r >= n; usable in parameter expressions.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = 1; v < n; v = v * 2) begin
         r = r + 1;
      end
      return r;
   endfunction

   localparam int DEF_SEL_LEN = clog2(DEF_NR_CH);

endpackage

// File: rtl/keymux_rr_stream_rr_pick.sv
// Rotating-priority request picker: first set request at or after ptr, wrapping at NR_CH-1.
module rr_pick
   import keymux_pkg::*;
#(
   parameter int  NR_CH   = DEF_NR_CH,
   localparam int SEL_LEN = clog2(NR_CH)
) (
   input  logic [NR_CH-1:0]   req,
   input  logic [SEL_LEN-1:0] ptr,
   output logic               gnt_vld,
   output logic [SEL_LEN-1:0] gnt
);

   int idx;

   // Walk from the farthest offset back to ptr so the nearest requester overwrites last and wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt     = '0;
      idx     = 0;
      for (int k = NR_CH - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NR_CH) begin
            idx = idx - NR_CH;
         end
         if (req[idx]) begin
            gnt_vld = 1'b1;
            gnt     = SEL_LEN'(idx);
         end
      end
   end

endmodule

// File: rtl/keymux_rr_stream.sv
// NR_CH-input valid/ready stream mux with round-robin or forced-key selection into a
// single registered output stage.
module keymux_rr_stream
   import keymux_pkg::*;
#(
   parameter int  NR_CH    = DEF_NR_CH,
   parameter int  DATA_LEN = DEF_DATA_LEN,
   localparam int SEL_LEN  = clog2(NR_CH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NR_CH-1:0]          in_valid,
   input  logic [NR_CH*DATA_LEN-1:0] in_data,
   output logic [NR_CH-1:0]          in_ready,
   input  logic                      force_en,
   input  logic [SEL_LEN-1:0]        force_sel,
   output logic                      out_valid,
   output logic [DATA_LEN-1:0]       out_data,
   output logic [SEL_LEN-1:0]        out_ch,
   input  logic                      out_ready
);

   logic                out_valid_q, out_valid_d;
   logic [DATA_LEN-1:0] out_data_q, out_data_d;
   logic [SEL_LEN-1:0]  out_ch_q, out_ch_d;
   logic [SEL_LEN-1:0]  rr_ptr_q, rr_ptr_d;
   logic [SEL_LEN-1:0]  rr_gnt, grant;
   logic                rr_gnt_vld, grant_vld;
   logic                load, take;
   logic [NR_CH-1:0]    fsel_valid;

   rr_pick #(.NR_CH(NR_CH)) u_pick (
      .req     (in_valid),
      .ptr     (rr_ptr_q),
      .gnt_vld (rr_gnt_vld),
      .gnt     (rr_gnt)
   );

   // A forced key beyond NR_CH-1 (non-power-of-two widths) never grants.
   always_comb begin
      fsel_valid  = in_valid >> force_sel;
      load        = ~out_valid_q | out_ready;
      if (force_en) begin
         grant     = force_sel;
         grant_vld = (int'(force_sel) < NR_CH) & fsel_valid[0];
      end else begin
         grant     = rr_gnt;
         grant_vld = rr_gnt_vld;
      end
      take        = ~rst & load & grant_vld;
      in_ready    = take ? (NR_CH'(1) << grant) : '0;

      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      rr_ptr_d    = rr_ptr_q;
      if (load) begin
         out_valid_d = take;
      end
      // The round-robin pointer only advances on unforced transfers, so forced periods keep its place.
      if (take) begin
         out_data_d = in_data[int'(grant)*DATA_LEN +: DATA_LEN];
         out_ch_d   = grant;
         if (!force_en) begin
            rr_ptr_d = (int'(grant) == NR_CH - 1) ? '0 : grant + SEL_LEN'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_keymux_rr_stream.sv
// Bench for keymux_rr_stream: directed vectors on a 4-channel instance, a hand sequence on a
// 3-channel instance, then random traffic on both against a queue-free behavioural model.
module tb_keymux_rr_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst4, force_en4, out_ready4, out_valid4;
   logic [3:0]  in_valid4, in_ready4;
   logic [31:0] in_data4;
   logic [1:0]  force_sel4, out_ch4;
   logic [7:0]  out_data4;

   logic        rst3, force_en3, out_ready3, out_valid3;
   logic [2:0]  in_valid3, in_ready3;
   logic [23:0] in_data3;
   logic [1:0]  force_sel3, out_ch3;
   logic [7:0]  out_data3;

   keymux_rr_stream #(.NR_CH(4), .DATA_LEN(8)) dut4 (
      .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
      .force_en(force_en4), .force_sel(force_sel4), .out_valid(out_valid4),
      .out_data(out_data4), .out_ch(out_ch4), .out_ready(out_ready4)
   );

   keymux_rr_stream #(.NR_CH(3), .DATA_LEN(8)) dut3 (
      .clk(clk), .rst(rst3), .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
      .force_en(force_en3), .force_sel(force_sel3), .out_valid(out_valid3),
      .out_data(out_data3), .out_ch(out_ch3), .out_ready(out_ready3)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic [31:0] data;
      logic        fe;
      logic [1:0]  fsel;
      logic        ordy;
      logic [3:0]  expReady;
      logic        expValid;
      logic [7:0]  expData;
      logic [1:0]  expCh;
      logic        chkData;
   } vec_t;

   vec_t vecs[$];

   // Behavioural model state per instance: index 0 = 4 channels, index 1 = 3 channels.
   int mValid[2], mData[2], mCh[2], mPtr[2];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int modelGrant(input int n, input int v, input bit fe, input int fs, input int ptr);
      if (fe) begin
         if (fs < n && ((v >> fs) & 1) == 1) return fs;
         return -1;
      end
      for (int k = 0; k < n; k++) begin
         if (((v >> ((ptr + k) % n)) & 1) == 1) return (ptr + k) % n;
      end
      return -1;
   endfunction

   function automatic int modelReady(input int m, input int n, input bit r, input int v, input bit fe,
                                     input int fs, input bit ordy);
      int g;
      g = modelGrant(n, v, fe, fs, mPtr[m]);
      if (r || !(mValid[m] == 0 || ordy) || g < 0) return 0;
      return 1 << g;
   endfunction

   task automatic modelStep(input int m, input int n, input bit r, input int v, input logic [31:0] d,
                            input bit fe, input int fs, input bit ordy);
      int g;
      g = modelGrant(n, v, fe, fs, mPtr[m]);
      if (r) begin
         mValid[m] = 0; mData[m] = 0; mCh[m] = 0; mPtr[m] = 0;
      end else if (mValid[m] == 0 || ordy) begin
         if (g >= 0) begin
            mValid[m] = 1;
            mData[m]  = int'((d >> (8 * g)) & 32'hFF);
            mCh[m]    = g;
            if (!fe) mPtr[m] = (g + 1) % n;
         end else begin
            mValid[m] = 0;
         end
      end
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      @(negedge clk);
      rst4 = v.rst; in_valid4 = v.valid; in_data4 = v.data;
      force_en4 = v.fe; force_sel4 = v.fsel; out_ready4 = v.ordy;
      #1;
      checkOutput($sformatf("vec%0d in_ready", idx), 32'(in_ready4), 32'(v.expReady));
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d out_valid", idx), 32'(out_valid4), 32'(v.expValid));
      if (v.chkData) begin
         checkOutput($sformatf("vec%0d out_data", idx), 32'(out_data4), 32'(v.expData));
         checkOutput($sformatf("vec%0d out_ch", idx), 32'(out_ch4), 32'(v.expCh));
      end
   endtask

   task automatic step3(input int idx, input logic r, input logic [2:0] v, input logic fe, input logic [1:0] fs,
                        input logic ordy, input logic [2:0] expReady, input logic expValid, input logic [1:0] expCh);
      @(negedge clk);
      rst3 = r; in_valid3 = v; in_data3 = 24'hC2C1C0;
      force_en3 = fe; force_sel3 = fs; out_ready3 = ordy;
      #1;
      checkOutput($sformatf("nc3 step%0d in_ready", idx), 32'(in_ready3), 32'(expReady));
      @(posedge clk);
      #1;
      checkOutput($sformatf("nc3 step%0d out_valid", idx), 32'(out_valid3), 32'(expValid));
      if (expValid) begin
         checkOutput($sformatf("nc3 step%0d out_ch", idx), 32'(out_ch3), 32'(expCh));
         checkOutput($sformatf("nc3 step%0d out_data", idx), 32'(out_data3), 32'(8'hC0) + 32'(expCh));
      end else if (r) begin
         checkOutput($sformatf("nc3 step%0d out_ch", idx), 32'(out_ch3), 32'd0);
      end
   endtask

   task automatic randomCycle(input int idx, input bit forceReset);
      bit r4, r3, fe4, fe3, o4, o3;
      int v4, v3, fs4, fs3, e4, e3;
      logic [31:0] d4, d3;
      r4 = forceReset || ($urandom_range(49) == 0);
      r3 = forceReset || ($urandom_range(49) == 0);
      v4 = int'($urandom_range(15)); v3 = int'($urandom_range(7));
      d4 = $urandom; d3 = $urandom & 32'h00FF_FFFF;
      fe4 = ($urandom_range(3) == 0); fe3 = ($urandom_range(3) == 0);
      fs4 = int'($urandom_range(3)); fs3 = int'($urandom_range(3));
      o4 = ($urandom_range(3) != 0); o3 = ($urandom_range(3) != 0);
      @(negedge clk);
      rst4 = r4; in_valid4 = 4'(v4); in_data4 = d4; force_en4 = fe4; force_sel4 = 2'(fs4); out_ready4 = o4;
      rst3 = r3; in_valid3 = 3'(v3); in_data3 = d3[23:0]; force_en3 = fe3; force_sel3 = 2'(fs3); out_ready3 = o3;
      e4 = modelReady(0, 4, r4, v4, fe4, fs4, o4);
      e3 = modelReady(1, 3, r3, v3, fe3, fs3, o3);
      #1;
      checkOutput($sformatf("rnd%0d nc4 in_ready", idx), 32'(in_ready4), 32'(e4));
      checkOutput($sformatf("rnd%0d nc3 in_ready", idx), 32'(in_ready3), 32'(e3));
      @(posedge clk);
      modelStep(0, 4, r4, v4, d4, fe4, fs4, o4);
      modelStep(1, 3, r3, v3, d3, fe3, fs3, o3);
      #1;
      checkOutput($sformatf("rnd%0d nc4 out_valid", idx), 32'(out_valid4), 32'(mValid[0]));
      checkOutput($sformatf("rnd%0d nc3 out_valid", idx), 32'(out_valid3), 32'(mValid[1]));
      if (mValid[0] != 0) begin
         checkOutput($sformatf("rnd%0d nc4 out_data", idx), 32'(out_data4), 32'(mData[0]));
         checkOutput($sformatf("rnd%0d nc4 out_ch", idx), 32'(out_ch4), 32'(mCh[0]));
      end
      if (mValid[1] != 0) begin
         checkOutput($sformatf("rnd%0d nc3 out_data", idx), 32'(out_data3), 32'(mData[1]));
         checkOutput($sformatf("rnd%0d nc3 out_ch", idx), 32'(out_ch3), 32'(mCh[1]));
      end
   endtask

   initial begin
      logic [31:0] da;
      da = 32'hA3A2A1A0;
      rst4 = 1'b1; in_valid4 = '0; in_data4 = '0; force_en4 = 1'b0; force_sel4 = '0; out_ready4 = 1'b0;
      rst3 = 1'b1; in_valid3 = '0; in_data3 = '0; force_en3 = 1'b0; force_sel3 = '0; out_ready3 = 1'b0;

      // Directed 4-channel vectors: reset, RR order, forced key, pointer preservation, backpressure, mid-op reset.
      vecs.push_back(vec_t'{1'b1, 4'hF, da, 1'b0, 2'd0, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b1});
      vecs.push_back(vec_t'{1'b1, 4'hF, da, 1'b0, 2'd0, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b1});
      vecs.push_back(vec_t'{1'b0, 4'hF, da, 1'b0, 2'd0, 1'b1, 4'h1, 1'b1, 8'hA0, 2'd0, 1'b1});
      vecs.push_back(vec_t'{1'b0, 4'hF, da, 1'b0, 2'd0, 1'b1, 4'h2, 1'b1, 8'hA1, 2'd1, 1'b1});
      vecs.push_back(vec_t'{1'b0, 4'hF, da, 1'b0, 2'd0, 1'b1, 4'h4, 1'b1, 8'hA2, 2'd2, 1'b1});
      vecs.push_back(vec_t'{1'b0, 4'hF, da, 1'b0, 2'd0, 1'b1, 4'h8, 1'b1, 8'hA3, 2'd3, 1'b1});
      vecs.push_back(vec_t'{1'b0, 4'hF, da, 1'b0, 2'd0, 1'b1, 4'h1, 1'b1, 8'hA0, 2'd0, 1'b1});
      vecs.push_back(vec_t'{1'b0, 4'hF, da, 1'b1, 2'd2, 1'b1, 4'h4, 1'b1, 8'hA2, 2'd2, 1'b1});
      vecs.push_back(vec_t'{1'b0, 4'hF, da, 1'b1, 2'd2, 1'b1, 4'h4, 1'b1, 8'hA2, 2'd2, 1'b1});
      vecs.push_back(vec_t'{1'b0, 4'hB, da, 1'b1, 2'd2, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0});
      vecs.push_back(vec_t'{1'b0, 4'hF, da, 1'b0, 2'd0, 1'b1, 4'h2, 1'b1, 8'hA1, 2'd1, 1'b1});
      vecs.push_back(vec_t'{1'b1, 4'hF, da, 1'b0, 2'd0, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b1});
      vecs.push_back(vec_t'{1'b0, 4'hF, da, 1'b0, 2'd0, 1'b1, 4'h1, 1'b1, 8'hA0, 2'd0, 1'b1});
      vecs.push_back(vec_t'{1'b0, 4'h2, 32'hA3A25CA0, 1'b0, 2'd0, 1'b1, 4'h2, 1'b1, 8'h5C, 2'd1, 1'b1});
      vecs.push_back(vec_t'{1'b0, 4'hF, da, 1'b0, 2'd0, 1'b0, 4'h0, 1'b1, 8'h5C, 2'd1, 1'b1});
      vecs.push_back(vec_t'{1'b0, 4'hF, da, 1'b0, 2'd0, 1'b0, 4'h0, 1'b1, 8'h5C, 2'd1, 1'b1});
      vecs.push_back(vec_t'{1'b0, 4'hF, da, 1'b0, 2'd0, 1'b0, 4'h0, 1'b1, 8'h5C, 2'd1, 1'b1});
      vecs.push_back(vec_t'{1'b0, 4'hF, da, 1'b0, 2'd0, 1'b1, 4'h4, 1'b1, 8'hA2, 2'd2, 1'b1});
      vecs.push_back(vec_t'{1'b0, 4'h4, 32'hA377A1A0, 1'b0, 2'd0, 1'b1, 4'h4, 1'b1, 8'h77, 2'd2, 1'b1});
      vecs.push_back(vec_t'{1'b1, 4'hF, da, 1'b0, 2'd0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b1});
      vecs.push_back(vec_t'{1'b0, 4'h9, da, 1'b0, 2'd0, 1'b1, 4'h1, 1'b1, 8'hA0, 2'd0, 1'b1});

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i], i);
      end

      // Three channels: pointer wraps 2 -> 0, and the unused key 3 never grants.
      step3(0, 1'b1, 3'b111, 1'b0, 2'd0, 1'b1, 3'b000, 1'b0, 2'd0);
      step3(1, 1'b1, 3'b111, 1'b0, 2'd0, 1'b1, 3'b000, 1'b0, 2'd0);
      step3(2, 1'b0, 3'b111, 1'b0, 2'd0, 1'b1, 3'b001, 1'b1, 2'd0);
      step3(3, 1'b0, 3'b111, 1'b0, 2'd0, 1'b1, 3'b010, 1'b1, 2'd1);
      step3(4, 1'b0, 3'b011, 1'b0, 2'd0, 1'b1, 3'b001, 1'b1, 2'd0);
      step3(5, 1'b0, 3'b111, 1'b0, 2'd0, 1'b1, 3'b010, 1'b1, 2'd1);
      step3(6, 1'b0, 3'b111, 1'b1, 2'd3, 1'b1, 3'b000, 1'b0, 2'd0);
      step3(7, 1'b0, 3'b111, 1'b0, 2'd0, 1'b1, 3'b100, 1'b1, 2'd2);
      step3(8, 1'b0, 3'b111, 1'b0, 2'd0, 1'b1, 3'b001, 1'b1, 2'd0);

      for (int m = 0; m < 2; m++) begin
         mValid[m] = 0; mData[m] = 0; mCh[m] = 0; mPtr[m] = 0;
      end
      for (int i = 0; i < 400; i++) begin
         randomCycle(i, i == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
